// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for uart_tx_arbiter.
// master drives the requester and transmitter-ready side; slave is the arbiter.
interface uart_tx_arbiter_if;
    logic [7:0] req0_data_in;
    logic       req0_data_in_valid;
    logic       req0_data_in_ready;
    logic       req0_lock;
    logic [7:0] req1_data_in;
    logic       req1_data_in_valid;
    logic       req1_data_in_ready;
    logic       req1_lock;
    logic [7:0] tx_data_out;
    logic       tx_data_out_valid;
    logic       tx_data_out_ready;
    logic [1:0] grant;
    logic       busy;

    modport master (
        output req0_data_in, req0_data_in_valid, req0_lock,
        output req1_data_in, req1_data_in_valid, req1_lock,
        output tx_data_out_ready,
        input  req0_data_in_ready, req1_data_in_ready,
        input  tx_data_out, tx_data_out_valid, grant, busy
    );

    modport slave (
        input  req0_data_in, req0_data_in_valid, req0_lock,
        input  req1_data_in, req1_data_in_valid, req1_lock,
        input  tx_data_out_ready,
        output req0_data_in_ready, req1_data_in_ready,
        output tx_data_out, tx_data_out_valid, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter feeding a UART transmitter through a single hold register.
// Optional UART_ARB_ROUND_ROBIN_EN: simultaneous requests go to the requester that did not own last.
module uart_tx_arbiter #(
    parameter int MAX_BURST    = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0]  BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [15:0] IDLE_LIMIT  = 16'(LOCK_TIMEOUT);

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [7:0]  hold_q;
    logic        hold_valid_q;
    logic [7:0]  burst_q;
    logic [15:0] idle_q;

    logic       owner0, owner1;
    logic       own_valid, own_lock, own_ready;
    logic [7:0] own_data;
    logic       accept, release_grant, pick1;

    assign owner0    = (state_q == OWN0);
    assign owner1    = (state_q == OWN1);
    assign own_valid = owner0 ? bus.req0_data_in_valid : bus.req1_data_in_valid;
    assign own_lock  = owner0 ? bus.req0_lock : bus.req1_lock;
    assign own_data  = owner0 ? bus.req0_data_in : bus.req1_data_in;
    // A byte can enter whenever the hold slot is empty or is being drained this cycle.
    assign own_ready = !hold_valid_q || bus.tx_data_out_ready;
    assign accept    = (owner0 || owner1) && own_valid && own_ready;

    assign release_grant =
        (accept && (!own_lock || (burst_q + 8'd1 == BURST_LIMIT))) ||
        (!own_lock && !own_valid) ||
        (!accept && !own_valid && own_lock && (idle_q + 16'd1 == IDLE_LIMIT));

`ifdef UART_ARB_ROUND_ROBIN_EN
    logic last_owner_q;
    assign pick1 = bus.req1_data_in_valid && (!bus.req0_data_in_valid || !last_owner_q);
`else
    assign pick1 = bus.req1_data_in_valid && !bus.req0_data_in_valid;
`endif

    assign bus.req0_data_in_ready = owner0 && own_ready;
    assign bus.req1_data_in_ready = owner1 && own_ready;
    assign bus.tx_data_out        = hold_q;
    assign bus.tx_data_out_valid  = hold_valid_q;
    assign bus.grant              = grant_q;
    assign bus.busy               = (state_q != IDLE) || hold_valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            burst_q      <= 8'd0;
            idle_q       <= 16'd0;
`ifdef UART_ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            // The hold slot drains regardless of who owns the grant.
            if (accept) begin
                hold_q       <= own_data;
                hold_valid_q <= 1'b1;
            end else if (bus.tx_data_out_ready) begin
                hold_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    burst_q <= 8'd0;
                    idle_q  <= 16'd0;
                    if (bus.req0_data_in_valid || bus.req1_data_in_valid) begin
                        state_q <= pick1 ? OWN1 : OWN0;
                        grant_q <= pick1 ? 2'b10 : 2'b01;
                    end
                end
                OWN0, OWN1: begin
                    if (accept) begin
                        burst_q <= burst_q + 8'd1;
                        idle_q  <= 16'd0;
                    end else if (!own_valid && own_lock) begin
                        idle_q <= idle_q + 16'd1;
                    end
                    if (release_grant) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
`ifdef UART_ARB_ROUND_ROBIN_EN
                        last_owner_q <= owner1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus hand sequences, with a byte scoreboard.
// Expectations follow UART_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_uart_tx_arbiter;
    localparam int MAXB = 16;
    localparam int TMO  = 8;
`ifdef UART_ARB_ROUND_ROBIN_EN
    localparam int S2_SECOND_GRANT = 2;
`else
    localparam int S2_SECOND_GRANT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.MAX_BURST(MAXB), .LOCK_TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       txr;
        logic [1:0] grant;
        logic       rdy0;
        logic       rdy1;
        logic       txv;
        logic [7:0] txd;
        logic       busy;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1, input logic txr);
        bus.req0_data_in_valid = v0;
        bus.req0_data_in       = d0;
        bus.req0_lock          = l0;
        bus.req1_data_in_valid = v1;
        bus.req1_data_in       = d1;
        bus.req1_lock          = l1;
        bus.tx_data_out_ready  = txr;
    endtask

    // Wait to the mid-cycle sample point and run the scoreboard on the handshakes of this cycle.
    task automatic neg();
        @(negedge clk);
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (bus.tx_data_out_valid && bus.tx_data_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_pop: got 0x%0h, expected no output byte", bus.tx_data_out);
                end else begin
                    check("sb_data", bus.tx_data_out, exp_q.pop_front());
                end
            end
            if (bus.req0_data_in_valid && bus.req0_data_in_ready) exp_q.push_back(bus.req0_data_in);
            if (bus.req1_data_in_valid && bus.req1_data_in_ready) exp_q.push_back(bus.req1_data_in);
        end
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_txd"},   bus.tx_data_out, 0);
        check({tag, "_txv"},   bus.tx_data_out_valid, 0);
        check({tag, "_rdy0"},  bus.req0_data_in_ready, 0);
        check({tag, "_rdy1"},  bus.req1_data_in_ready, 0);
        check({tag, "_grant"}, bus.grant, 0);
        check({tag, "_busy"},  bus.busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        post();
        post();
        neg();
        check_all_zero("reset");
        post();
        rst = 1'b1;
    endtask

    int gr[200];
    int c16;
    int idx;
    int got0;

    initial begin
        // Scenario 1: single unlocked byte.
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
        // Scenario 5: back-pressure holds 0x55, then 0x66 replaces it with no bubble.
        vecs[4]  = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
        vecs[5]  = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1};
        vecs[6]  = '{1'b1, 8'h66, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        vecs[7]  = '{1'b1, 8'h66, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        vecs[8]  = '{1'b1, 8'h66, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h66, 1'b0};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v0, vecs[i].d0, vecs[i].l0, vecs[i].v1, vecs[i].d1, vecs[i].l1, vecs[i].txr);
            neg();
            check($sformatf("v%0d_grant", i), bus.grant, vecs[i].grant);
            check($sformatf("v%0d_rdy0", i),  bus.req0_data_in_ready, vecs[i].rdy0);
            check($sformatf("v%0d_rdy1", i),  bus.req1_data_in_ready, vecs[i].rdy1);
            check($sformatf("v%0d_txv", i),   bus.tx_data_out_valid, vecs[i].txv);
            check($sformatf("v%0d_txd", i),   bus.tx_data_out, vecs[i].txd);
            check($sformatf("v%0d_busy", i),  bus.busy, vecs[i].busy);
            post();
        end

        // Scenario 2: both requesters valid straight out of reset.
        do_reset();
        drive(1'b1, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
        neg();
        check("s2_arb_grant", bus.grant, 0);
        post();
        neg();
        check("s2_first_grant", bus.grant, 1);
        check("s2_first_rdy1", bus.req1_data_in_ready, 0);
        post();
        drive(1'b1, 8'h11, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
        neg();
        check("s2_gap_grant", bus.grant, 0);
        post();
        neg();
        check("s2_second_grant", bus.grant, S2_SECOND_GRANT);
        post();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            neg();
            post();
        end
        check("s2_drained", exp_q.size(), 0);

        // Scenario 3: locked burst from req1 capped at MAX_BURST with req0 waiting.
        c16  = -1;
        idx  = 0;
        got0 = -1;
        for (int c = 0; c < 200 && idx < 20; c++) begin
            drive((c >= 2) && (got0 < 0), 8'h77, 1'b0, 1'b1, 8'(idx), 1'b1, 1'b1);
            neg();
            gr[c] = int'(bus.grant);
            if (bus.req0_data_in_valid && bus.req0_data_in_ready) got0 = idx;
            if (bus.req1_data_in_ready) begin
                idx++;
                if (idx == 16) c16 = c;
            end
            post();
        end
        check("s3_bytes_sent", idx, 20);
        check("s3_req0_slot", got0, 16);
        if (c16 >= 0) begin
            check("s3_release_grant", gr[c16 + 1], 0);
            check("s3_req0_grant", gr[c16 + 2], 1);
            check("s3_req1_regrant", gr[c16 + 4], 2);
        end else begin
            checks++;
            errors++;
            $display("FAIL s3_burst: got fewer than 16 req1 bytes, expected 16 before release");
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        neg();
        post();
        neg();
        check("s3_idle_grant", bus.grant, 0);
        post();
        neg();
        post();
        check("s3_drained", exp_q.size(), 0);

        // Scenario 4: locked owner goes quiet until the timeout revokes it.
        drive(1'b1, 8'h31, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        neg();
        post();
        neg();
        check("s4_grant", bus.grant, 1);
        post();
        for (int k = 1; k <= TMO; k++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
            neg();
            check($sformatf("s4_locked_grant_%0d", k), bus.grant, 1);
            post();
        end
        neg();
        check("s4_revoked", bus.grant, 0);
        post();
        neg();
        check("s4_req1_grant", bus.grant, 2);
        check("s4_req1_rdy", bus.req1_data_in_ready, 1);
        post();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        neg();
        post();
        neg();
        post();
        check("s4_drained", exp_q.size(), 0);

        // Scenario 6: reset while 0xAA is held under back-pressure.
        drive(1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        neg();
        post();
        neg();
        check("s6_grant", bus.grant, 1);
        post();
        neg();
        check("s6_held_txv", bus.tx_data_out_valid, 1);
        check("s6_held_txd", bus.tx_data_out, 8'hAA);
        post();
        rst = 1'b0;
        drive(1'b1, 8'hAB, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        neg();
        post();
        neg();
        check_all_zero("s6_rst");
        post();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1);
        neg();
        check("s6_arb_grant", bus.grant, 0);
        post();
        neg();
        check("s6_req1_grant", bus.grant, 2);
        check("s6_req1_rdy", bus.req1_data_in_ready, 1);
        post();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        neg();
        check("s6_txv", bus.tx_data_out_valid, 1);
        check("s6_txd", bus.tx_data_out, 8'hC3);
        post();
        neg();
        post();
        check("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 16, giving the maximum bytes accepted per grant while lock is held (legal range 1..255).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 64, giving the idle cycles after which a locked grant is revoked (legal range 1..65535).
REQ-003 The block SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  in  1  synchronous, active-low reset.
REQ-005 The block SHALL have ports req0_data_in  in  8, req0_data_in_valid  in  1, req0_data_in_ready  out  1: requester 0 byte ready/valid.
REQ-006 The block SHALL have port req0_lock  in  1  requester 0 asks to keep the grant across bytes.
REQ-007 The block SHALL have ports req1_data_in, req1_data_in_valid, req1_data_in_ready and req1_lock, identical to requester 0.
REQ-008 The block SHALL have ports tx_data_out  out  8, tx_data_out_valid  out  1, tx_data_out_ready  in  1: connection to the UART transmitter ready/valid.
REQ-009 The block SHALL have port grant  out  2  one-hot current owner; 2'b00 when idle.
REQ-010 The block SHALL have port busy  out  1  high when not IDLE or when the hold register is full.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, OWN0 and OWN1.
REQ-012 In IDLE with any reqN_data_in_valid high, the FSM SHALL move to OWNN at the next edge; no byte is accepted in IDLE (1-cycle arbitration latency).
REQ-013 The winner when both requesters are valid in IDLE SHALL follow the Configuration section.
REQ-014 In OWNN, reqN_data_in_ready SHALL equal (!hold_valid | tx_data_out_ready); the non-owner ready SHALL be 0.
REQ-015 An accepted byte (valid & ready) SHALL load the 8-bit hold register and set hold_valid at the same edge; tx_data_out equals the hold register and tx_data_out_valid equals hold_valid.
REQ-016 hold_valid SHALL clear on tx_data_out_ready & hold_valid unless a new byte is accepted in the same cycle, in which case it stays set with the new data (full throughput, no bubble).
REQ-017 tx_data_out SHALL stay stable while tx_data_out_valid is high and tx_data_out_ready is low.
REQ-018 An 8-bit burst counter SHALL clear on entry to OWNN and increment on each accepted byte.
REQ-019 OWNN SHALL return to IDLE at the edge of an accept when reqN_lock is low or the counter reaches MAX_BURST with that accept.
REQ-020 OWNN SHALL return to IDLE when reqN_lock is low and reqN_data_in_valid is low.
REQ-021 A 16-bit idle counter SHALL count OWNN cycles with reqN_data_in_valid low and reqN_lock high; it SHALL clear on any accept, and the FSM SHALL return to IDLE when it reaches LOCK_TIMEOUT.
REQ-022 Draining of the hold register SHALL be independent of FSM state; a byte already held SHALL be delivered after the grant is released.
REQ-023 The owner SHALL be recorded in last_owner on every transition from OWNN to IDLE.

Reset
REQ-024 With rst low at a rising edge, the block SHALL set: state IDLE; hold_valid 0; hold register 8'h00; both counters 0; last_owner 1.
REQ-025 Reset SHALL drive all outputs to 0: tx_data_out 8'h00, valid 0, both readies 0, grant 2'b00, busy 0.
REQ-026 A reset asserted mid-burst SHALL discard the held byte; no partial state SHALL survive.

Configuration
REQ-027 With macro UART_ARB_ROUND_ROBIN_EN defined, a simultaneous request in IDLE SHALL be granted to the requester that is not last_owner.
REQ-028 Without UART_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win a simultaneous request, and last_owner SHALL be unused.

Verification
REQ-029 Scenario 1: req0 sends 0x41, lock=0, tx_ready=1 -> grant=01 one cycle later; accept; tx_data_out=0x41 valid next cycle; FSM back to IDLE.
REQ-030 Scenario 2 (RR on): both valid from reset -> req0 served first (last_owner=1), then req1; RR off -> req0 served twice while it stays valid.
REQ-031 Scenario 3: req1 lock=1 streams 20 bytes 0x00..0x13, MAX_BURST=16, req0 pending -> release after 0x0F; req0 granted next; req1 remainder follows.
REQ-032 Scenario 4: req0 lock=1, valid low for LOCK_TIMEOUT=8 cycles -> grant=00 on the 8th idle cycle edge; pending req1 granted next cycle.
REQ-033 Scenario 5: tx_ready held low with 0x55 held -> owner ready=0, tx_data_out stable at 0x55; tx_ready rises with 0x66 offered -> 0x66 loaded same edge, valid stays high.
REQ-034 Scenario 6: rst low mid-burst with byte 0xAA held -> next edge all outputs 0, grant=00; after release, a new req1 byte arbitrates normally.
